// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder built from two half adders; optional subtract via SERIAL_ADDER_SUB_EN

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             h;
    logic             g;
    logic             s_bit;
    logic             p;
    logic             cy;
    logic             sub_eff;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Full adder: first cell adds the operand bits, second folds in the carry
    halfAdder ha1 (
        .a     (ra[0]),
        .b     (rb[0]),
        .sum   (h),
        .carry (g)
    );

    halfAdder ha2 (
        .a     (h),
        .b     (c),
        .sum   (s_bit),
        .carry (p)
    );

    assign cy   = g | p;
    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start outside IDLE is simply dropped
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, shift one bit per RUN cycle, latch result on the last bit
    always_ff @(posedge clk) begin
        if (reset) begin
            ra   <= '0;
            rb   <= '0;
            rs   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            S    <= '0;
            Cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= A;
                        rb  <= sub_eff ? ~B : B;
                        c   <= sub_eff ? 1'b1 : Cin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    c   <= cy;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rs  <= {s_bit, rs[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        S    <= {s_bit, rs[WIDTH-1:1]};
                        Cout <= cy;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// One-bit half adder cell
module halfAdder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)

module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;

    int n_cmp;
    int n_err;
    int done_cnt;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses mid-cycle
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One addition with start pulsed for one cycle; poke!=0 re-pulses start (with other operands) at edge poke
    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, input logic [W-1:0] exp_s,
                          input logic exp_c, input logic [W-1:0] prev_s, input logic prev_c,
                          input int poke);
        A = a; B = b; Cin = ci; sub = sb; start = 1'b1;
        step();
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done0"}, {31'd0, done}, 32'd0);
        start = 1'b0; A = ~a; B = ~b; Cin = ~ci; sub = ~sb;
        for (int k = 1; k < W; k++) begin
            if (poke != 0 && k == poke - 1) begin
                start = 1'b1; A = 8'h01; B = 8'h01;
            end
            step();
            if (poke != 0 && k == poke) start = 1'b0;
            chk({tag, "_run"}, {22'd0, busy, done, Cout, S}, {22'd0, 1'b1, 1'b0, prev_c, prev_s});
        end
        step();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_S"}, {24'd0, S}, {24'd0, exp_s});
        chk({tag, "_Cout"}, {31'd0, Cout}, {31'd0, exp_c});
        step();
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int d0;
        n_cmp = 0; n_err = 0; done_cnt = 0;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_state", {21'd0, busy, done, Cout, S}, 32'd0);

        // zeros, then basic additions with stable-result checks during RUN
        do_add("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        do_add("ff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 0);
        do_add("3c0f", 8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 8'h00, 1'b1, 0);

        // start during RUN is ignored; exactly one done
        d0 = done_cnt;
        do_add("ign", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 8'h4C, 1'b0, 3);
        step(); step(); step();
        chk("ign_pulses", done_cnt - d0, 32'd1);
        chk("ign_hold", {23'd0, busy, Cout, S}, {23'd0, 1'b0, 1'b1, 8'h00});

        // reset mid-operation aborts with no done
        d0 = done_cnt;
        A = 8'h55; B = 8'hAA; Cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_e4", {22'd0, busy, done, Cout, S}, 32'd0);
        step();
        chk("abort_e5", {22'd0, busy, done, Cout, S}, 32'd0);
        for (int k = 0; k < 10; k++) step();
        chk("abort_nodone", done_cnt - d0, 32'd0);
        do_add("fresh", 8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 0);

        // reset and start on the same edge: reset wins
        A = 8'h01; B = 8'h01; start = 1'b1; reset = 1'b1;
        step();
        start = 1'b0; reset = 1'b0;
        chk("rst_wins", {22'd0, busy, done, Cout, S}, 32'd0);

        // start held high: re-accepted every W+2 cycles
        d0 = done_cnt;
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("hold_done", {31'd0, done}, {31'd0, (i % 10) == 8});
            if (done === 1'b1) chk("hold_res", {23'd0, Cout, S}, {23'd0, 1'b0, 8'h46});
        end
        start = 1'b0;
        chk("hold_pulses", done_cnt - d0, 32'd3);
        step(); step(); step();

`ifdef SERIAL_ADDER_SUB_EN
        do_add("sub1", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h46, 1'b0, 0);
        do_add("sub2", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h0F, 1'b1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, LSB-first adder for the arithmetic homework datapath. It sits directly downstream of `halfAdder`: it instantiates two `halfAdder` cells as a full adder and feeds them one operand bit per cycle, with a carry flip-flop closing the loop. It accepts a WIDTH-bit operand pair on a start pulse and returns the WIDTH-bit sum and carry-out after WIDTH cycles. A start/busy/done handshake lets a controller sequence successive additions.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  input  1: single clock, rising edge.
- `reset`  input  1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  input  1: request to begin an addition; accepted only in IDLE.
- `A`  input  WIDTH: operand A; sampled only on the accepting edge.
- `B`  input  WIDTH: operand B; sampled only on the accepting edge.
- `Cin`  input  1: carry-in; sampled only on the accepting edge.
- `busy`  output  1: high in RUN and DONE.
- `done`  output  1: one-cycle pulse; `S` and `Cout` are valid while it is high.
- `S`  output  WIDTH: registered sum; holds the last result.
- `Cout`  output  1: registered carry-out; holds the last result.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: processes one bit per cycle.
  - DONE: asserts `done` for one cycle.
- IDLE→RUN on `start`=1. On that edge: A→shift register `ra`, B→`rb`, `Cin`→carry flop `c`, bit counter `cnt` cleared to 0.
- Each RUN edge:
  - half adder 1: `h = ra[0]^rb[0]`, `g = ra[0]&rb[0]`.
  - half adder 2: `s = h^c`, `p = h&c`.
  - `c <= g|p`.
  - `ra` and `rb` shift right by one.
  - `s` shifts into the MSB of the partial-sum register `rs`.
  - `cnt` increments.
- RUN→DONE on the edge where `cnt` = WIDTH-1, i.e. after the last bit is processed. On that edge `S <= {s, rs[WIDTH-1:1]}` and `Cout <= g|p`.
- DONE→IDLE unconditionally on the next edge.
- `start` in RUN or DONE is ignored. It is not queued, and the operands are not resampled.
- `A`, `B` and `Cin` may change freely after the accepting edge without affecting the result in progress.
- Arithmetic is unsigned modulo 2^WIDTH. `Cout` is the (WIDTH+1)th bit of A+B+Cin.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `S`=0, `Cout`=0, and all internal registers 0.
- Latency:
  - `start` is sampled at edge 0.
  - `busy` is high from edge 0.
  - `done`, `S` and `Cout` update at edge WIDTH; `done` is high in the cycle following edge WIDTH.
  - Back at IDLE and `busy`=0 after edge WIDTH+1.
- Throughput: one addition per WIDTH+2 cycles. `start` may be held high continuously; it is re-accepted at edge WIDTH+1+1.
- Reset mid-operation aborts the addition. The block returns to the reset values on that edge and `done` is not pulsed.
- If `reset` and `start` are high on the same edge, reset wins.
- `S` and `Cout` are stable from edge WIDTH until the next completed addition. They do not change during RUN.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - Adds input port `sub` (1 bit), sampled with the operands.
  - When `sub`=1, ~B is loaded into `rb` and `c` is forced to 1 (`Cin` ignored), giving S = A−B mod 2^WIDTH.
  - `Cout`=1 means no borrow (A≥B).
- `SERIAL_ADDER_SUB_EN` undefined:
  - No `sub` port; addition only.
  - Behaviour is identical to `sub`=0.

## Test plan
- After reset, WIDTH=8, A=0x00, B=0x00, Cin=0, start pulse at edge 0 → `done` high after edge 8, S=0x00, Cout=0, `busy` low after edge 9.
- A=0xFF, B=0x01, Cin=0 → S=0x00, Cout=1. Then A=0x3C, B=0x0F, Cin=1 → S=0x4C, Cout=0.
- Start an addition with A=0x80, B=0x80. Pulse `start` again with A=0x01, B=0x01 at edge 3 → ignored; result S=0x00, Cout=1, exactly one `done` pulse.
- Start with A=0x55, B=0xAA and assert `reset` at edge 4 → `busy`=0, S=0x00, Cout=0 at edge 5, and no `done`. A fresh start then completes normally.
- `start` held high for 30 cycles with A=0x12, B=0x34 → `done` pulses every 10 cycles, each with S=0x46, Cout=0.
- With `SERIAL_ADDER_SUB_EN`: sub=1, A=0x10, B=0x01 → S=0x0F, Cout=1. Then sub=1, A=0x01, B=0x02 → S=0xFF, Cout=0.
